// File: rtl/reg_bus_master_pkg.sv
// Protocol byte codes, FSM state encoding and small helpers shared by reg_bus_master.
package reg_bus_master_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h57;  // 'W'
  localparam logic [7:0] CMD_READ  = 8'h52;  // 'R'
  localparam logic [7:0] RSP_ACK   = 8'h06;
  localparam logic [7:0] RSP_NAK   = 8'h15;

  typedef enum logic [2:0] {
    S_IDLE,
    S_W_ADDR,
    S_W_DATA,
    S_WRITE,
    S_R_ADDR,
    S_R_WAIT,
    S_R_CAP,
    S_RESP
  } state_t;

  // States that expect the next byte of a frame and therefore run the inter-byte timer.
  function automatic logic is_frame_wait(state_t s);
    return (s == S_W_ADDR) || (s == S_W_DATA) || (s == S_R_ADDR);
  endfunction

  function automatic int tmo_width(int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/reg_bus_master_if.sv
// UART byte path, register bus and status signals of reg_bus_master, named from the master's view.
interface reg_bus_master_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
);
  logic [7:0]            i_rx_data;
  logic                  i_rx_valid;
  logic [7:0]            o_tx_data;
  logic                  o_tx_valid;
  logic                  i_tx_ready;
  logic [ADDR_WIDTH-1:0] o_bus_addr;
  logic [DATA_WIDTH-1:0] o_bus_wdata;
  logic                  o_bus_wr;
  logic [DATA_WIDTH-1:0] i_bus_rdata;
  logic                  o_busy;
  logic                  o_err;

  modport master (
    input  i_rx_data, i_rx_valid, i_tx_ready, i_bus_rdata,
    output o_tx_data, o_tx_valid, o_bus_addr, o_bus_wdata, o_bus_wr, o_busy, o_err
  );

  modport slave (
    output i_rx_data, i_rx_valid, i_tx_ready, i_bus_rdata,
    input  o_tx_data, o_tx_valid, o_bus_addr, o_bus_wdata, o_bus_wr, o_busy, o_err
  );

endinterface

// File: rtl/reg_bus_master.sv
// Turns host 'W' addr data / 'R' addr byte frames into single register accesses and replies ACK/NAK/data.
// Read data is sampled 2 edges after the address is driven; the reply is held until i_tx_ready, stray RX bytes raise o_err.
module reg_bus_master
  import reg_bus_master_pkg::*;
#(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic             i_clk,
  input  logic             i_rst,
  reg_bus_master_if.master bus
);

  localparam int               CNT_W    = tmo_width(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] bus_addr_q, bus_addr_d;
  logic [DATA_WIDTH-1:0] bus_wdata_q, bus_wdata_d;
  logic                  bus_wr_q, bus_wr_d;
  logic [7:0]            tx_data_q, tx_data_d;
  logic                  tx_valid_q, tx_valid_d;
  logic                  busy_q, busy_d;
  logic                  err_q, err_d;

  logic                  rx_vld;
  logic [7:0]            rx_byte;
  logic                  frame_wait;
  logic                  timeout;

  assign rx_vld     = bus.i_rx_valid;
  assign rx_byte    = bus.i_rx_data;
  assign frame_wait = is_frame_wait(state_q);
  // An arriving byte beats the terminal count in the same cycle.
  assign timeout    = frame_wait && !rx_vld && (cnt_q == CNT_LAST);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    tx_data_d   = tx_data_q;
    err_d       = 1'b0;

    if (rx_vld || !frame_wait) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (rx_vld) begin
          if (rx_byte == CMD_WRITE) begin
            state_d = S_W_ADDR;
          end else if (rx_byte == CMD_READ) begin
            state_d = S_R_ADDR;
          end else begin
            state_d   = S_RESP;
            tx_data_d = RSP_NAK;
            err_d     = 1'b1;
          end
        end
      end
      S_W_ADDR: begin
        if (rx_vld) begin
          bus_addr_d = rx_byte[ADDR_WIDTH-1:0];
          state_d    = S_W_DATA;
        end
      end
      S_W_DATA: begin
        if (rx_vld) begin
          bus_wdata_d = rx_byte[DATA_WIDTH-1:0];
          state_d     = S_WRITE;
        end
      end
      S_WRITE: begin
        state_d   = S_RESP;
        tx_data_d = RSP_ACK;
      end
      S_R_ADDR: begin
        if (rx_vld) begin
          bus_addr_d = rx_byte[ADDR_WIDTH-1:0];
          state_d    = S_R_WAIT;
        end
      end
      S_R_WAIT: begin
        state_d = S_R_CAP;
      end
      S_R_CAP: begin
        tx_data_d = bus.i_bus_rdata;
        state_d   = S_RESP;
      end
      S_RESP: begin
        if (tx_valid_q && bus.i_tx_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (timeout) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      err_d   = 1'b1;
    end

    // Bytes arriving while a command is executing or replying are dropped.
    if (rx_vld && !frame_wait && (state_q != S_IDLE)) begin
      err_d = 1'b1;
    end

    bus_wr_d   = (state_d == S_WRITE);
    tx_valid_d = (state_d == S_RESP);
    busy_d     = (state_d != S_IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_wr_q    <= 1'b0;
      tx_data_q   <= '0;
      tx_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_wr_q    <= bus_wr_d;
      tx_data_q   <= tx_data_d;
      tx_valid_q  <= tx_valid_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  assign bus.o_tx_data   = tx_data_q;
  assign bus.o_tx_valid  = tx_valid_q;
  assign bus.o_bus_addr  = bus_addr_q;
  assign bus.o_bus_wdata = bus_wdata_q;
  assign bus.o_bus_wr    = bus_wr_q;
  assign bus.o_busy      = busy_q;
  assign bus.o_err       = err_q;

endmodule
